window_min_detector: RTL and testbench
======================================

Name: window_min_detector

Overview:
- Streaming trough detector for the AGC datapath; the minimum-side counterpart of the max selector used in peak detection.
- Accepts a stream of signed 8-bit samples and reports the minimum of each non-overlapping window of 2^WIN_LOG2 accepted samples.
- Sits beside the peak path so the gain loop can form peak-to-trough envelope estimates.

Parameters:
- WIDTH, 8, sample width (signed two's complement).
- WIN_LOG2, 4, log2 of window length (default window = 16 samples); legal range 1..8.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enb  in  1  clock enable; when low, all state holds except min_valid, which still clears.
- clear  in  1  synchronous window restart; discards the partial window.
- in_valid  in  1  sample qualifier.
- in0  in  WIDTH  signed sample.
- min_out  out  WIDTH  signed minimum of the last completed window, registered.
- min_valid  out  1  one-cycle pulse: min_out updated this cycle.
- min_ready  out  1  level: at least one window completed since reset or clear.
- win_cnt  out  WIN_LOG2  number of samples accepted in the current window.

Behaviour:
- Reset is synchronous and active-high on clk, with priority over everything. On reset:
  - min_out = 0, min_valid = 0, min_ready = 0, win_cnt = 0.
  - acc = +2^(WIDTH-1)-1 (127 for WIDTH 8).
  - state = FILL.
- Accept condition: enb & in_valid & ~clear & ~reset.
- Internal signals:
  - acc: running minimum, WIDTH bits, signed.
  - cand = min2(in0, acc): signed compare; in0 is selected when in0 <= acc.
- FSM states:
  - FILL: no window completed yet; min_ready = 0.
  - RUN: at least one window completed; min_ready = 1.
- Accepted sample, win_cnt < 2^WIN_LOG2-1: acc <= cand; win_cnt <= win_cnt+1.
- Accepted sample, win_cnt == 2^WIN_LOG2-1 (window end):
  - min_out <= cand; min_valid <= 1.
  - acc <= +max; win_cnt <= 0 (natural wrap).
  - state <= RUN.
- Latency: min_out and min_valid assert on the clock edge that accepts the last window sample, so they are visible in the following cycle. min_valid is high for exactly one cycle.
- min_valid <= 0 on every edge that is not a window end, regardless of enb.
- min_out holds its value between window ends; it is never affected by enb low, clear, or partial windows.
- clear (with enb = 1):
  - acc <= +max, win_cnt <= 0, state <= FILL.
  - min_out is retained; min_ready drops the next cycle.
  - A sample presented in the same cycle is dropped.
- clear while enb = 0 is ignored (enb gates clear).
- Arithmetic: comparison only, no width growth. Signed full range (-128..127) must be handled. An all-+127 window yields 127; any -128 sample forces a result of -128.
- Consecutive back-to-back windows with in_valid held high produce a min_valid pulse every 2^WIN_LOG2 cycles with no bubble.
- in_valid gaps only stretch the window; they never alter the result.
- Reset mid-window discards the partial window; the next window counts from the first sample after reset is released.

Decomposition:
- Shared package (agc_pkg):
  - AGC_WIDTH = 8.
  - AGC_SMAX = 127, AGC_SMIN = -128.
  - Default WIN_LOG2.
  - State encoding typedef: FILL = 0, RUN = 1.
- Sub-module min_select2: purely combinational signed 2-input minimum (in0, in1 -> out0; selects in0 when in0 <= in1). It is the mirror of the existing max selector and is reusable by the peak-to-trough logic.

Test Plan:
- Reset, then 16 accepted samples 10, 9, ..., -5 -> one cycle after the 16th accept: min_valid = 1 for one cycle, min_out = -5, min_ready = 1, win_cnt = 0.
- Window of 16 samples all 127 -> min_out = 127. Next window of 15 × 0 plus one -128 -> min_out = -128.
- in_valid toggling 1/0 with enb = 1, samples 3, 7, -2, 5 repeating -> min_out = -2 after 16 accepts (32 cycles); min_valid pulses once.
- 8 samples of -50, then clear = 1 together with in_valid and sample -100, then 16 samples of 20:
  - min_out = 20, not -50 or -100.
  - min_ready = 0 from the cycle after clear until the 16th accept.
- enb low for 5 cycles mid-window with in_valid = 1 and sample -90 presented -> sample ignored, win_cnt frozen, result excludes -90. Also: a min_valid pulse coinciding with enb falling still lasts one cycle.
- Reset asserted after 10 accepts of -7, then 16 samples of 4 -> min_out = 0 during reset, then 4. No min_valid pulse occurs until 16 samples after reset is released.

Source files
------------

// File: rtl/agc_pkg.sv
// ---------------------------------------------------------------------------
// agc_pkg
// Shared definitions for the AGC datapath: default sample width, signed
// full-scale limits, default window length and the trough detector state
// encoding.
// Ports: none (package).
// ---------------------------------------------------------------------------
package agc_pkg;

   localparam int AGC_WIDTH    = 8;
   localparam int AGC_SMAX     = 127;
   localparam int AGC_SMIN     = -128;
   localparam int AGC_WIN_LOG2 = 4;

   // FILL: no window completed yet; RUN: at least one window completed.
   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } agc_state_e;

endpackage

// File: rtl/window_min_detector_if.sv
// ---------------------------------------------------------------------------
// window_min_detector_if
// Sample stream and result bundle of the window minimum detector.
//   enb, clear, in_valid, in0      : driven by the sample source (master)
//   min_out, min_valid, min_ready,
//   win_cnt                        : driven by the detector (slave)
// ---------------------------------------------------------------------------
interface window_min_detector_if
   import agc_pkg::*;
#(
   parameter int WIDTH    = AGC_WIDTH,
   parameter int WIN_LOG2 = AGC_WIN_LOG2
);

   logic                       enb;
   logic                       clear;
   logic                       in_valid;
   logic signed [WIDTH-1:0]    in0;
   logic signed [WIDTH-1:0]    min_out;
   logic                       min_valid;
   logic                       min_ready;
   logic        [WIN_LOG2-1:0] win_cnt;

   modport master (
      output enb, clear, in_valid, in0,
      input  min_out, min_valid, min_ready, win_cnt
   );

   modport slave (
      input  enb, clear, in_valid, in0,
      output min_out, min_valid, min_ready, win_cnt
   );

endinterface

// File: rtl/min_select2.sv
// ---------------------------------------------------------------------------
// min_select2
// Combinational signed two-input minimum; the mirror of the max selector.
//   in0, in1 : signed operands
//   out0     : in0 when in0 <= in1, else in1
// ---------------------------------------------------------------------------
module min_select2
   import agc_pkg::*;
#(
   parameter int WIDTH = AGC_WIDTH
) (
   input  logic signed [WIDTH-1:0] in0,
   input  logic signed [WIDTH-1:0] in1,
   output logic signed [WIDTH-1:0] out0
);

   assign out0 = (in0 <= in1) ? in0 : in1;

endmodule

// File: rtl/window_min_detector.sv
// ---------------------------------------------------------------------------
// window_min_detector
// Streaming trough detector: reports the signed minimum of each
// non-overlapping window of 2^WIN_LOG2 accepted samples.
//   clk    : system clock
//   reset  : synchronous active-high reset, highest priority
//   bus    : window_min_detector_if.slave
//            enb       clock enable (min_valid still clears when low)
//            clear     window restart, gated by enb
//            in_valid  sample qualifier
//            in0       signed sample
//            min_out   registered minimum of the last completed window
//            min_valid one-cycle pulse when min_out updates
//            min_ready level, a window completed since reset/clear
//            win_cnt   samples accepted in the current window
// ---------------------------------------------------------------------------
module window_min_detector
   import agc_pkg::*;
#(
   parameter int WIDTH    = AGC_WIDTH,
   parameter int WIN_LOG2 = AGC_WIN_LOG2
) (
   input  logic                  clk,
   input  logic                  reset,
   window_min_detector_if.slave  bus
);

   localparam logic signed [WIDTH-1:0] SMAX     = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIN_LOG2-1:0]     CNT_LAST = {WIN_LOG2{1'b1}};

   agc_state_e                 state;
   logic signed [WIDTH-1:0]    acc;
   logic signed [WIDTH-1:0]    cand;
   logic signed [WIDTH-1:0]    min_out;
   logic                       min_valid;
   logic                       min_ready;
   logic        [WIN_LOG2-1:0] win_cnt;

   min_select2 #(
      .WIDTH (WIDTH)
   ) u_min_select2 (
      .in0  (bus.in0),
      .in1  (acc),
      .out0 (cand)
   );

   // min_valid defaults low on every edge, so a pulse never outlives one
   // cycle even while enb is low. The final window sample goes straight to
   // min_out through cand so back-to-back windows need no bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= FILL;
         acc       <= SMAX;
         min_out   <= '0;
         min_valid <= 1'b0;
         min_ready <= 1'b0;
         win_cnt   <= '0;
      end else begin
         min_valid <= 1'b0;
         if (bus.enb) begin
            if (bus.clear) begin
               // Partial window and any same-cycle sample are discarded;
               // min_out keeps the last completed result.
               state     <= FILL;
               acc       <= SMAX;
               win_cnt   <= '0;
               min_ready <= 1'b0;
            end else if (bus.in_valid) begin
               if (win_cnt == CNT_LAST) begin
                  min_out   <= cand;
                  min_valid <= 1'b1;
                  acc       <= SMAX;
                  win_cnt   <= '0;
                  state     <= RUN;
                  min_ready <= 1'b1;
               end else begin
                  acc     <= cand;
                  win_cnt <= win_cnt + 1'b1;
               end
            end
         end
      end
   end

   assign bus.min_out   = min_out;
   assign bus.min_valid = min_valid;
   assign bus.min_ready = min_ready;
   assign bus.win_cnt   = win_cnt;

endmodule

// File: tb/tb_window_min_detector.sv
// ---------------------------------------------------------------------------
// tb_window_min_detector
// Self-checking bench for window_min_detector: a queue-based window model
// compared every cycle, directed scenarios with literal expectations, and a
// randomized stream.
// ---------------------------------------------------------------------------
module tb_window_min_detector;
   import agc_pkg::*;

   localparam int WIDTH    = 8;
   localparam int WIN_LOG2 = 4;
   localparam int WIN      = 1 << WIN_LOG2;

   logic clk;
   logic reset;

   window_min_detector_if #(.WIDTH(WIDTH), .WIN_LOG2(WIN_LOG2)) bus ();

   window_min_detector #(
      .WIDTH    (WIDTH),
      .WIN_LOG2 (WIN_LOG2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: the current window is a queue of accepted samples;
   // its minimum is taken when the queue reaches the window length.
   logic signed [WIDTH-1:0] win_q[$];
   logic signed [WIDTH-1:0] e_out   = '0;
   bit                      e_valid = 1'b0;
   bit                      e_ready = 1'b0;

   always @(posedge clk) begin
      logic signed [WIDTH-1:0] m;
      e_valid = 1'b0;
      if (reset) begin
         win_q.delete();
         e_out   = '0;
         e_ready = 1'b0;
      end else if (bus.enb) begin
         if (bus.clear) begin
            win_q.delete();
            e_ready = 1'b0;
         end else if (bus.in_valid) begin
            win_q.push_back(bus.in0);
            if (win_q.size() == WIN) begin
               m = win_q[0];
               foreach (win_q[i]) if (win_q[i] < m) m = win_q[i];
               e_out   = m;
               e_valid = 1'b1;
               e_ready = 1'b1;
               win_q.delete();
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("min_out",   int'(bus.min_out),   int'(e_out));
         check("min_valid", int'(bus.min_valid), int'(e_valid));
         check("min_ready", int'(bus.min_ready), int'(e_ready));
         check("win_cnt",   int'(bus.win_cnt),   win_q.size());
      end
   end

   // Apply inputs for one cycle; returns at the next falling edge, where the
   // outputs reflect the rising edge that consumed these inputs.
   task automatic drive(input bit v, input int x, input bit e = 1'b1,
                        input bit c = 1'b0, input bit r = 1'b0);
      bus.in_valid = v;
      bus.in0      = 8'(x);
      bus.enb      = e;
      bus.clear    = c;
      reset        = r;
      @(negedge clk);
   endtask

   int pulses;
   int pat[4] = '{3, 7, -2, 5};

   initial begin
      reset        = 1'b1;
      bus.enb      = 1'b0;
      bus.clear    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in0      = '0;
      @(negedge clk);
      @(negedge clk);
      chk_en = 1'b1;

      // Reset state
      check("rst_min_out",   int'(bus.min_out),   0);
      check("rst_min_valid", int'(bus.min_valid), 0);
      check("rst_min_ready", int'(bus.min_ready), 0);
      check("rst_win_cnt",   int'(bus.win_cnt),   0);

      // Descending ramp 10 .. -5
      for (int i = 0; i < 16; i++) drive(1'b1, 10 - i);
      check("ramp_min_out",   int'(bus.min_out),   -5);
      check("ramp_min_valid", int'(bus.min_valid), 1);
      check("ramp_min_ready", int'(bus.min_ready), 1);
      check("ramp_win_cnt",   int'(bus.win_cnt),   0);
      drive(1'b0, 0);
      check("ramp_pulse_end", int'(bus.min_valid), 0);

      // Full-scale extremes, back to back
      for (int i = 0; i < 16; i++) drive(1'b1, AGC_SMAX);
      check("allmax_min_out", int'(bus.min_out), 127);
      for (int i = 0; i < 15; i++) drive(1'b1, 0);
      drive(1'b1, AGC_SMIN);
      check("smin_min_out", int'(bus.min_out), -128);

      // in_valid toggling stretches the window only
      pulses = 0;
      for (int i = 0; i < 32; i++) begin
         drive(i % 2 == 0, pat[(i / 2) % 4]);
         if (bus.min_valid) pulses++;
      end
      check("toggle_min_out", int'(bus.min_out), -2);
      check("toggle_pulses",  pulses, 1);

      // clear discards partial window and the same-cycle sample
      for (int i = 0; i < 8; i++) drive(1'b1, -50);
      drive(1'b1, -100, 1'b1, 1'b1);
      check("clear_ready_drop", int'(bus.min_ready), 0);
      check("clear_keeps_out",  int'(bus.min_out),   -2);
      for (int i = 0; i < 15; i++) drive(1'b1, 20);
      check("clear_ready_low", int'(bus.min_ready), 0);
      drive(1'b1, 20);
      check("clear_min_out",   int'(bus.min_out),   20);
      check("clear_ready_up",  int'(bus.min_ready), 1);

      // enb low holds state; gated clear is ignored
      for (int i = 0; i < 6; i++) drive(1'b1, 30);
      for (int i = 0; i < 5; i++) drive(1'b1, -90, 1'b0);
      check("enb_win_cnt", int'(bus.win_cnt), 6);
      drive(1'b1, -90, 1'b0, 1'b1);
      check("enb_clear_ready", int'(bus.min_ready), 1);
      check("enb_clear_cnt",   int'(bus.win_cnt),   6);
      for (int i = 0; i < 10; i++) drive(1'b1, 25);
      check("enb_min_out", int'(bus.min_out), 25);
      check("enb_pulse",   int'(bus.min_valid), 1);
      drive(1'b1, -90, 1'b0);
      check("enb_pulse_one_cycle", int'(bus.min_valid), 0);
      check("enb_out_hold",        int'(bus.min_out),   25);

      // Reset mid-window
      for (int i = 0; i < 10; i++) drive(1'b1, -7);
      drive(1'b1, -7, 1'b1, 1'b0, 1'b1);
      check("midrst_min_out", int'(bus.min_out),   0);
      check("midrst_ready",   int'(bus.min_ready), 0);
      drive(1'b1, -7, 1'b1, 1'b0, 1'b1);
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         drive(1'b1, 4);
         if (bus.min_valid) pulses++;
      end
      check("midrst_no_pulse", pulses, 0);
      drive(1'b1, 4);
      check("midrst_min_out4", int'(bus.min_out), 4);

      // Randomized stream with extreme-biased samples
      for (int i = 0; i < 3000; i++) begin
         int sel;
         int x;
         sel = int'($urandom_range(0, 9));
         if (sel == 0)      x = AGC_SMIN;
         else if (sel == 1) x = AGC_SMAX;
         else               x = int'($urandom_range(0, 255)) - 128;
         drive($urandom_range(0, 9) < 7, x,
               $urandom_range(0, 9) != 0,
               $urandom_range(0, 63) == 0,
               $urandom_range(0, 255) == 0);
      end

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
